// File: rtl/rw_stage_pipe.sv
// rw_stage_pipe: registered register-writeback stage of the 5-stage pipeline.
// Takes one retiring instruction per cycle from MA, picks the writeback value
// (load data, call link address or ALU result) and drives the regfile write port
// one cycle later. A load whose data has not arrived parks the stage in WAIT_LD
// and stalls MA until the data shows up or the wait times out.
module rw_stage_pipe #(
    parameter int XLEN       = 32,
    parameter int RADDR_W    = 4,
    parameter int RD_LSB     = 22,
    parameter int PC_STEP    = 4,
    parameter int LD_TIMEOUT = 16,
    parameter int ZERO_REG   = 0,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ma_valid,
    output logic               rw_ready,
    input  logic [XLEN-1:0]    pc_in,
    input  logic [XLEN-1:0]    alu_result,
    input  logic [31:0]        inst_in,
    input  logic [21:0]        control_in,
    input  logic [XLEN-1:0]    ld_result,
    input  logic               ld_valid,
    output logic               wb_en,
    output logic [RADDR_W-1:0] wb_addr,
    output logic [XLEN-1:0]    wb_data,
    output logic               ld_err,
    output logic [CNT_W-1:0]   retire_cnt
);

    localparam int TMR_W = $clog2(LD_TIMEOUT);
    localparam logic [RADDR_W-1:0] LINK_REG   = '1;
    localparam logic [TMR_W-1:0]   TIMER_LAST = TMR_W'(LD_TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        WAIT_LD
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic [RADDR_W-1:0] wait_addr;
    logic               wait_we;

    logic               in_ld;
    logic               in_wb;
    logic               in_call;
    logic [RADDR_W-1:0] in_rd;
    logic [RADDR_W-1:0] in_addr;
    logic [XLEN-1:0]    in_data;
    logic               in_we;
    logic               transfer;
    logic               unused_bits;

    // Only a few instruction and control bits matter to this stage; the rest are
    // folded here so they are visibly consumed.
    assign unused_bits = ^{inst_in, control_in, pc_in};

    // Decode of the instruction MA is presenting: the writeback value follows
    // the priority load > call link > ALU, and calls always write the link register.
    assign in_ld    = control_in[1];
    assign in_wb    = control_in[6];
    assign in_call  = control_in[8];
    assign in_rd    = inst_in[RD_LSB +: RADDR_W];
    assign in_addr  = in_call ? LINK_REG : in_rd;
    assign in_data  = in_ld   ? ld_result
                    : in_call ? pc_in + XLEN'(PC_STEP)
                    :           alu_result;
    assign in_we    = in_wb && !((ZERO_REG != 0) && (in_addr == '0));
    assign transfer = ma_valid && rw_ready;

    // Writeback FSM: all outputs are registered. While a load is outstanding only
    // the destination and write enable are kept, since the data always comes from
    // ld_result when it finally arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rw_ready   <= 1'b1;
            timer      <= '0;
            wait_addr  <= '0;
            wait_we    <= 1'b0;
            wb_en      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            ld_err     <= 1'b0;
            retire_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        if (in_ld && !ld_valid) begin
                            state     <= WAIT_LD;
                            rw_ready  <= 1'b0;
                            timer     <= '0;
                            wait_addr <= in_addr;
                            wait_we   <= in_we;
                            wb_en     <= 1'b0;
                        end else begin
                            wb_en      <= in_we;
                            wb_addr    <= in_addr;
                            wb_data    <= in_data;
                            retire_cnt <= retire_cnt + CNT_W'(1);
                        end
                    end else begin
                        wb_en <= 1'b0;
                    end
                end
                WAIT_LD: begin
                    if (ld_valid) begin
                        state      <= IDLE;
                        rw_ready   <= 1'b1;
                        wb_en      <= wait_we;
                        wb_addr    <= wait_addr;
                        wb_data    <= ld_result;
                        retire_cnt <= retire_cnt + CNT_W'(1);
                    end else if (timer == TIMER_LAST) begin
                        state    <= IDLE;
                        rw_ready <= 1'b1;
                        ld_err   <= 1'b1;
                        wb_en    <= 1'b0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                        wb_en <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    rw_ready <= 1'b1;
                    wb_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule
